// File: rtl/seq_muldiv_unit.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply, restoring divide, architectural HI/LO.
// Define MULDIV_SIGNED_EN to make ops 00/10 signed (magnitude datapath plus a FIX sign-correction cycle).
module seq_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              md_valid_in,
    input  logic [1:0]        md_op_in,
    input  logic [DATA_W-1:0] md_rs_data_in,
    input  logic [DATA_W-1:0] md_rt_data_in,
    input  logic              md_flush_in,
    input  logic [1:0]        md_hilo_we_in,
    input  logic [DATA_W-1:0] md_hilo_data_in,
    output logic              md_ready_out,
    output logic              md_busy_out,
    output logic              md_done_out,
    output logic [DATA_W-1:0] md_hi_out,
    output logic [DATA_W-1:0] md_lo_out,
    output logic              md_div_by_zero_out,
    output logic [1:0]        md_state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] shq_q, shq_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic              op_signed;
    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign accept = (state_q == S_IDLE) && md_valid_in && !md_flush_in;

`ifdef MULDIV_SIGNED_EN
    assign op_signed = ~md_op_in[0];
`else
    assign op_signed = 1'b0;
`endif

    assign rs_neg = op_signed & md_rs_data_in[DATA_W-1];
    assign rt_neg = op_signed & md_rt_data_in[DATA_W-1];
    assign rs_mag = rs_neg ? -md_rs_data_in : md_rs_data_in;
    assign rt_mag = rt_neg ? -md_rt_data_in : md_rt_data_in;

    // acc holds the product high half / partial remainder; shq holds the multiplier / dividend-then-quotient.
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_trial;
    logic              div_ok;
    logic [DATA_W-1:0] step_acc, step_shq;
    logic [2*DATA_W-1:0] prod_neg;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shq_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
        div_trial = {acc_q, shq_q[DATA_W-1]} - {1'b0, opb_q};
        div_ok    = ~div_trial[DATA_W];
        prod_neg  = -{acc_q, shq_q};
        if (is_div_q) begin
            step_acc = div_ok ? div_trial[DATA_W-1:0] : {acc_q[DATA_W-2:0], shq_q[DATA_W-1]};
            step_shq = {shq_q[DATA_W-2:0], div_ok};
        end else begin
            step_acc = mul_sum[DATA_W:1];
            step_shq = {mul_sum[0], shq_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        shq_d    = shq_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (md_hilo_we_in[1]) hi_d = md_hilo_data_in;
                if (md_hilo_we_in[0]) lo_d = md_hilo_data_in;
                if (accept) begin
                    dbz_d    = 1'b0;
                    cnt_d    = CNT_W'(DATA_W - 1);
                    is_div_d = md_op_in[1];
                    neg_d    = rs_neg ^ rt_neg;
                    rneg_d   = rs_neg;
                    acc_d    = '0;
                    if (md_op_in[1]) begin
                        shq_d = rs_mag;
                        opb_d = rt_mag;
                        if (md_rt_data_in == '0) begin
                            hi_d    = md_rs_data_in;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        shq_d   = rt_mag;
                        opb_d   = rs_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (md_flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    shq_d = step_shq;
                    if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
                        state_d = S_FIX;
`else
                        hi_d    = step_acc;
                        lo_d    = step_shq;
                        state_d = S_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                if (md_flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d = neg_q  ? -shq_q : shq_q;
                        hi_d = rneg_q ? -acc_q : acc_q;
                    end else if (neg_q) begin
                        {hi_d, lo_d} = prod_neg;
                    end else begin
                        hi_d = acc_q;
                        lo_d = shq_q;
                    end
                    state_d = S_DONE;
                end
            end
            // Result is already architectural in DONE, so a flush here cannot squash it.
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            shq_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shq_q    <= shq_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
        end
    end

    assign md_ready_out       = (state_q == S_IDLE);
    assign md_busy_out        = (state_q != S_IDLE);
    assign md_done_out        = (state_q == S_DONE);
    assign md_hi_out          = hi_q;
    assign md_lo_out          = lo_q;
    assign md_div_by_zero_out = dbz_q;
    assign md_state_out       = state_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Testbench for seq_muldiv_unit: directed scenarios plus random operations checked against an arithmetic model.
module tb_seq_muldiv_unit;
  localparam int DW = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_b;
  logic          md_valid_in;
  logic [1:0]    md_op_in;
  logic [DW-1:0] md_rs_data_in;
  logic [DW-1:0] md_rt_data_in;
  logic          md_flush_in;
  logic [1:0]    md_hilo_we_in;
  logic [DW-1:0] md_hilo_data_in;
  logic          md_ready_out;
  logic          md_busy_out;
  logic          md_done_out;
  logic [DW-1:0] md_hi_out;
  logic [DW-1:0] md_lo_out;
  logic          md_div_by_zero_out;
  logic [1:0]    md_state_out;

  int n_total = 0;
  int n_pass  = 0;

  seq_muldiv_unit #(.DATA_W(DW)) dut (
    .clk                (clk),
    .rst_b              (rst_b),
    .md_valid_in        (md_valid_in),
    .md_op_in           (md_op_in),
    .md_rs_data_in      (md_rs_data_in),
    .md_rt_data_in      (md_rt_data_in),
    .md_flush_in        (md_flush_in),
    .md_hilo_we_in      (md_hilo_we_in),
    .md_hilo_data_in    (md_hilo_data_in),
    .md_ready_out       (md_ready_out),
    .md_busy_out        (md_busy_out),
    .md_done_out        (md_done_out),
    .md_hi_out          (md_hi_out),
    .md_lo_out          (md_lo_out),
    .md_div_by_zero_out (md_div_by_zero_out),
    .md_state_out       (md_state_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // reference model: returns {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit     sgn;
    longint sa, sb, q, r;
    logic [63:0] p;
    sgn = SIGNED_EN && !op[0];
    if (!op[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      return p;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [DW-1:0] b);
    if (op[1] && b == 0) return 1;
    return SIGNED_EN ? DW + 2 : DW + 1;
  endfunction

  // driver: called at a negedge in IDLE; returns at the first negedge after the accept edge (cycle 1)
  task automatic start_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    md_valid_in   = 1'b1;
    md_op_in      = op;
    md_rs_data_in = a;
    md_rt_data_in = b;
    @(negedge clk);
    md_valid_in = 1'b0;
  endtask

  // waits (bounded) for done starting from cycle k0, checks latency, results, flag, and return to IDLE
  task automatic wait_done(input string tag, input int k0, input int exp_lat,
                           input logic [63:0] exp_hl, input logic exp_dbz, input bit flush_in_done);
    int k;
    k = k0;
    while (!md_done_out && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(md_hi_out), 64'(exp_hl[63:32]));
    chk({tag, "_lo"}, 64'(md_lo_out), 64'(exp_hl[31:0]));
    chk({tag, "_dbz"}, 64'(md_div_by_zero_out), 64'(exp_dbz));
    if (flush_in_done) md_flush_in = 1'b1;
    @(negedge clk);
    md_flush_in = 1'b0;
    chk({tag, "_done_pulse"}, 64'(md_done_out), 64'd0);
    chk({tag, "_ready"}, 64'(md_ready_out), 64'd1);
    if (flush_in_done) chk({tag, "_flushdone_hilo"}, {md_hi_out, md_lo_out}, exp_hl);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    start_op(op, a, b);
    wait_done(tag, 1, latency(op, b), model(op, a, b), op[1] && (b == 0), 1'b0);
  endtask

  task automatic no_done_window(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (md_done_out) pulses++;
    end
    chk(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    logic [1:0]    r_op;
    logic [DW-1:0] r_a, r_b;
    logic [63:0]   prev_hl;

    rst_b = 1'b0;
    md_valid_in = 1'b0;
    md_op_in = 2'b00;
    md_rs_data_in = '0;
    md_rt_data_in = '0;
    md_flush_in = 1'b0;
    md_hilo_we_in = 2'b00;
    md_hilo_data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(md_hi_out), 64'd0);
    chk("rst_lo", 64'(md_lo_out), 64'd0);
    chk("rst_ready", 64'(md_ready_out), 64'd1);
    chk("rst_busy", 64'(md_busy_out), 64'd0);
    chk("rst_done", 64'(md_done_out), 64'd0);
    chk("rst_dbz", 64'(md_div_by_zero_out), 64'd0);
    chk("rst_state", 64'(md_state_out), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // full-scale unsigned multiply
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_const", 64'(md_hi_out), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(md_lo_out), 64'h0000_0001);

    // op 00/10 with negative operands (signedness follows build)
    run_op("mult_neg", 2'b00, -32'sd3, 32'd7);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // divide by zero, sticky flag
    run_op("divu_zero", 2'b11, 32'd100, 32'd0);

    // flush at accept+10: no done, HI/LO kept, flag cleared by accept
    prev_hl = {md_hi_out, md_lo_out};
    start_op(2'b11, 32'd1000, 32'd7);
    chk("busy_in_run", 64'(md_busy_out), 64'd1);
    repeat (9) @(negedge clk);
    md_flush_in = 1'b1;
    @(negedge clk);
    md_flush_in = 1'b0;
    chk("flush_ready", 64'(md_ready_out), 64'd1);
    chk("flush_done", 64'(md_done_out), 64'd0);
    chk("flush_hilo", {md_hi_out, md_lo_out}, prev_hl);
    chk("flush_dbz_cleared", 64'(md_div_by_zero_out), 64'd0);
    no_done_window("flush_no_done", 40);
    run_op("divu_1000_7", 2'b11, 32'd1000, 32'd7);
    chk("divu_1000_7_lo_const", 64'(md_lo_out), 64'd142);
    chk("divu_1000_7_hi_const", 64'(md_hi_out), 64'd6);

    // mthi while busy ignored; valid while busy ignored
    prev_hl = {md_hi_out, md_lo_out};
    start_op(2'b01, 32'd3, 32'd5);
    md_hilo_we_in = 2'b10;
    md_hilo_data_in = 32'h1234;
    md_valid_in = 1'b1;
    md_op_in = 2'b11;
    md_rs_data_in = 32'd9;
    md_rt_data_in = 32'd0;
    @(negedge clk);
    md_hilo_we_in = 2'b00;
    md_valid_in = 1'b0;
    chk("mthi_busy_ignored", 64'(md_hi_out), 64'(prev_hl[63:32]));
    wait_done("multu_3_5", 2, latency(2'b01, 32'd5), model(2'b01, 32'd3, 32'd5), 1'b0, 1'b0);

    // mtlo in IDLE
    md_hilo_we_in = 2'b01;
    md_hilo_data_in = 32'h55;
    @(negedge clk);
    md_hilo_we_in = 2'b00;
    chk("mtlo_idle_lo", 64'(md_lo_out), 64'h55);
    chk("mtlo_idle_hi", 64'(md_hi_out), 64'd0);

    // flush+valid in IDLE: not accepted
    md_flush_in = 1'b1;
    md_valid_in = 1'b1;
    md_op_in = 2'b01;
    @(negedge clk);
    md_flush_in = 1'b0;
    md_valid_in = 1'b0;
    chk("flush_blocks_accept", 64'(md_ready_out), 64'd1);

    // mthi together with accept, then result overwrites; flush in DONE keeps result
    md_hilo_we_in = 2'b10;
    md_hilo_data_in = 32'hABCD;
    start_op(2'b01, 32'h1_0001, 32'h2_0003);
    md_hilo_we_in = 2'b00;
    chk("mthi_with_accept", 64'(md_hi_out), 64'hABCD);
    wait_done("multu_ovr", 1, latency(2'b01, 32'h2_0003), model(2'b01, 32'h1_0001, 32'h2_0003), 1'b0, 1'b1);

    // asynchronous reset mid-operation
    start_op(2'b11, 32'd12345, 32'd17);
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(md_hi_out), 64'd0);
    chk("mid_rst_lo", 64'(md_lo_out), 64'd0);
    chk("mid_rst_ready", 64'(md_ready_out), 64'd1);
    chk("mid_rst_busy", 64'(md_busy_out), 64'd0);
    chk("mid_rst_done", 64'(md_done_out), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    no_done_window("rst_no_done", 40);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/seq_muldiv_unit.md
SEQ_MULDIV_UNIT -- requirements
Module: seq_muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand, HI and LO width; legal values are even and 8..64.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(DATA_W)+1, giving the iteration counter width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_b  in  1  reset, asynchronous, active-low.
REQ-005 md_valid_in  in  1  operation request, sampled only when md_ready_out=1.
REQ-006 md_op_in  in  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 md_rs_data_in / md_rt_data_in  in  DATA_W  multiplicand/dividend, multiplier/divisor (forwarded values).
REQ-008 md_flush_in  in  1  abort the in-flight operation (branch/exception squash).
REQ-009 md_hilo_we_in  in  2  bit1 mthi, bit0 mtlo write enables.
REQ-010 md_hilo_data_in  in  DATA_W  mthi/mtlo data.
REQ-011 md_ready_out  out  1  high only in IDLE.
REQ-012 md_busy_out  out  1  high in RUN, FIX, DONE; pipeline stalls on mfhi/mflo while high.
REQ-013 md_done_out  out  1  one-cycle completion pulse.
REQ-014 md_hi_out / md_lo_out  out  DATA_W  architectural HI/LO registers.
REQ-015 md_div_by_zero_out  out  1  sticky flag for the last completed divide; cleared on the next accept.

Function
REQ-016 States SHALL be IDLE, RUN, FIX, DONE.
REQ-017 Accept condition: IDLE & md_valid_in & !md_flush_in; operands and op SHALL be latched on the accept edge.
REQ-018 Multiply: radix-2 shift-add, one bit per RUN cycle, DATA_W RUN cycles; HI:LO = full 2*DATA_W product.
REQ-019 Divide: restoring, one quotient bit per RUN cycle, DATA_W RUN cycles; LO = quotient, HI = remainder.
REQ-020 Counter SHALL load DATA_W-1 on accept and decrement each RUN cycle; RUN->FIX on the edge where the counter is 0.
REQ-021 FIX SHALL apply the sign fixup and write HI/LO; FIX->DONE unconditionally; DONE->IDLE unconditionally.
REQ-022 md_done_out SHALL be high exactly in DONE, i.e. DATA_W+2 cycles after the accept edge; HI/LO SHALL already hold the new result in that cycle.
REQ-023 Divide with divisor 0 SHALL skip RUN/FIX and go IDLE->DONE: HI=dividend, LO=all ones, md_div_by_zero_out=1, done 1 cycle after accept.
REQ-024 md_flush_in in RUN/FIX SHALL return the FSM to IDLE on the next edge with HI/LO unchanged and no done pulse.
REQ-025 md_flush_in in DONE SHALL NOT squash the result, because HI/LO are already written.
REQ-026 md_hilo_we_in writes SHALL take effect only in IDLE; writes in any other state SHALL be ignored.
REQ-027 A simultaneous mthi/mtlo write and accept in IDLE SHALL perform both; the operation result overwrites HI/LO later.
REQ-028 md_valid_in while not ready SHALL be ignored; the requester holds the request until ready.

Reset
REQ-029 rst_b low SHALL immediately force IDLE, counter 0, HI=LO=0, md_div_by_zero_out=0, md_done_out=0, md_busy_out=0 and md_ready_out=1.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-031 Macro MULDIV_SIGNED_EN.
- Defined: ops 00/10 are signed. Magnitudes are taken at accept and FIX negates the results:
  - product negative iff the operand signs differ;
  - quotient negative iff the signs differ;
  - remainder takes the sign of the dividend;
  - MIN/-1 gives LO=MIN, HI=0.
- Undefined: ops 00/10 behave as 01/11, FIX is bypassed (RUN->DONE), and done comes DATA_W+1 cycles after accept.

Verification
REQ-032 DATA_W=32, multu 0xFFFFFFFF*0xFFFFFFFF -> done at accept+34 (signed build); HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 Signed build, mult -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 divu 100/0 -> done 1 cycle after accept; HI=100, LO=0xFFFFFFFF, div_by_zero=1; next accept clears the flag.
REQ-035 Flush at accept+10 of divu 1000/7 -> back to IDLE next cycle, no done, HI/LO keep prior values; new divu 1000/7 -> LO=142, HI=6.
REQ-036 mthi 0x1234 while busy -> ignored; mtlo 0x55 in IDLE -> LO=0x55 next cycle.
REQ-037 Assert rst_b low at accept+5 -> outputs at reset values immediately; no done pulse after release.
